// File: rtl/psram_responder_pkg.sv
// Shared PSRAM protocol definitions: responder state encoding, opcodes, and address length.
// memCtrl imports this same package, so both sides agree on these values.
package psram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WAIT,
        WDATA,
        RDATA,
        IGNORE
    } PsramState;

    localparam logic [7:0]  OP_WRITE   = 8'h02;
    localparam logic [7:0]  OP_READ    = 8'h0B;
    localparam int unsigned ADDR_BYTES = 3;

endpackage

// File: rtl/psram_responder_if.sv
// Pad-side PSRAM bus bundle: memCtrl drives the master side and the responder drives the slave side.
interface psram_responder_if;

    logic       cs;
    logic       sclk;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       oe;
    logic       busy;
    logic       cmd_error;

    modport master (
        output cs, sclk, data_in,
        input  data_out, oe, busy, cmd_error
    );

    modport slave (
        input  cs, sclk, data_in,
        output data_out, oe, busy, cmd_error
    );

endinterface

// File: rtl/psram_responder_array.sv
// Single-port synchronous-read byte RAM backing the responder; it maps onto FPGA block RAM.
module psram_array #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [7:0]  INIT_VALUE = 8'h00
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**DEPTH_LOG2] = '{default: INIT_VALUE};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/psram_responder.sv
// Device-side model of the 8-bit serial PSRAM. It samples the pad synchronously,
// decodes command, address, and data bytes, and serves them from an internal byte array.
module psram_responder
    import psram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [7:0]  INIT_VALUE  = 8'h00
) (
    input  logic       clkSys,
    input  logic       reset,
    input  logic       i_psram_cs,
    input  logic       i_psram_sclk,
    input  logic [7:0] i_psram_data,
    output logic [7:0] o_psram_data,
    output logic       o_psram_oe,
    output logic       o_cmdError,
    output logic       o_busy
);

    logic       cs_r;
    logic       sclk_r;
    logic       sclk_q;
    logic [7:0] data_r;
    logic       rise;
    logic       fall;

    PsramState   state, state_n;
    logic [23:0] addr, addr_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [3:0]  dummy_cnt, dummy_cnt_n;
    logic        is_read, is_read_n;
    logic [7:0]  odata_n;
    logic        oe_n;
    logic        err_n;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            cs_r   <= 1'b1;
            sclk_r <= 1'b0;
            sclk_q <= 1'b0;
            data_r <= '0;
        end else begin
            cs_r   <= i_psram_cs;
            sclk_r <= i_psram_sclk;
            sclk_q <= sclk_r;
            data_r <= i_psram_data;
        end
    end

    assign rise   = !sclk_q && sclk_r;
    assign fall   = sclk_q && !sclk_r;
    assign o_busy = !cs_r && (state != IDLE);

    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr         <= '0;
            byte_cnt     <= '0;
            dummy_cnt    <= '0;
            is_read      <= 1'b0;
            o_psram_data <= '0;
            o_psram_oe   <= 1'b0;
            o_cmdError   <= 1'b0;
        end else begin
            state        <= state_n;
            addr         <= addr_n;
            byte_cnt     <= byte_cnt_n;
            dummy_cnt    <= dummy_cnt_n;
            is_read      <= is_read_n;
            o_psram_data <= odata_n;
            o_psram_oe   <= oe_n;
            o_cmdError   <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        byte_cnt_n  = byte_cnt;
        dummy_cnt_n = dummy_cnt;
        is_read_n   = is_read;
        odata_n     = o_psram_data;
        oe_n        = o_psram_oe;
        err_n       = o_cmdError;
        mem_we      = 1'b0;

        // Deselect wins over any same-cycle sclk edge, so a byte racing CS high is dropped.
        if (cs_r) begin
            state_n = IDLE;
            oe_n    = 1'b0;
        end else begin
            case (state)
                IDLE: state_n = CMD;
                CMD: begin
                    if (rise) begin
                        if (data_r == OP_WRITE || data_r == OP_READ) begin
                            is_read_n  = (data_r == OP_READ);
                            byte_cnt_n = '0;
                            state_n    = ADDR;
                        end else begin
                            err_n   = 1'b1;
                            state_n = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (rise) begin
                        addr_n     = {addr[15:0], data_r};
                        byte_cnt_n = byte_cnt + 2'd1;
                        if (byte_cnt == 2'(ADDR_BYTES - 1)) begin
                            dummy_cnt_n = '0;
                            state_n     = is_read ? WAIT : WDATA;
                        end
                    end
                end
                WAIT: begin
                    if (rise) begin
                        dummy_cnt_n = dummy_cnt + 4'd1;
                        if (dummy_cnt == 4'(WAIT_CYCLES - 1)) begin
                            state_n = RDATA;
                        end
                    end
                end
                WDATA: begin
                    if (rise) begin
                        mem_we = 1'b1;
                        addr_n = addr + 24'd1;
                    end
                end
                // The array reads the current address every cycle; bumping addr here prefetches the next byte.
                RDATA: begin
                    if (fall) begin
                        odata_n = mem_rdata;
                        oe_n    = 1'b1;
                        addr_n  = addr + 24'd1;
                    end
                end
                IGNORE:  oe_n = 1'b0;
                default: state_n = IDLE;
            endcase
        end
    end

    psram_array #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .INIT_VALUE(INIT_VALUE)
    ) u_array (
        .clk  (clkSys),
        .we   (mem_we),
        .addr (addr[DEPTH_LOG2-1:0]),
        .wdata(data_r),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_psram_responder.sv
// Self-checking bench for psram_responder: table-driven write/read transactions with a
// queue of expected read bytes, plus hand-written sequences for aborts, bad opcodes, and reset.
module tb_psram_responder;
    import psram_pkg::*;

    localparam int unsigned WAIT_N = 4;

    logic clkSys = 1'b0;
    logic reset;
    psram_responder_if bus ();

    always #5 clkSys = ~clkSys;

    psram_responder #(
        .DEPTH_LOG2 (10),
        .WAIT_CYCLES(WAIT_N),
        .INIT_VALUE (8'h00)
    ) dut (
        .clkSys      (clkSys),
        .reset       (reset),
        .i_psram_cs  (bus.cs),
        .i_psram_sclk(bus.sclk),
        .i_psram_data(bus.data_in),
        .o_psram_data(bus.data_out),
        .o_psram_oe  (bus.oe),
        .o_cmdError  (bus.cmd_error),
        .o_busy      (bus.busy)
    );

    typedef struct {
        bit               is_wr;
        logic [23:0]      addr;
        int unsigned      len;
        logic [3:0][7:0]  bytes;   // write data or expected read data, index 0 first
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[9];

    function automatic vec_t mk(input bit w, input logic [23:0] a, input int unsigned n,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
        vec_t v;
        v.is_wr    = w;
        v.addr     = a;
        v.len      = n;
        v.bytes[0] = b0;
        v.bytes[1] = b1;
        v.bytes[2] = b2;
        v.bytes[3] = b3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %0h", name, bus.data_out);
        end else begin
            e = exp_q.pop_front();
            check(name, {24'h0, bus.data_out}, {24'h0, e});
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clkSys);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.data_in = b;
        tick(1);
        bus.sclk = 1'b1;
        tick(3);
        bus.sclk = 1'b0;
        tick(3);
    endtask

    task automatic start_txn();
        bus.cs = 1'b0;
        tick(3);
    endtask

    task automatic end_txn();
        bus.cs = 1'b1;
        tick(4);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic do_write(input logic [23:0] a, input int unsigned n, input logic [3:0][7:0] d);
        start_txn();
        send_byte(OP_WRITE);
        send_addr(a);
        for (int unsigned i = 0; i < n; i++) send_byte(d[i]);
        end_txn();
    endtask

    // Read phase after the address: WAIT_N-1 plain dummy pulses, then n pulses whose falls deliver data.
    task automatic read_phase(input int unsigned n);
        for (int unsigned d = 0; d + 1 < WAIT_N; d++) begin
            send_byte(8'h00);
            check("oe_dummy", {31'h0, bus.oe}, 32'h0);
        end
        for (int unsigned i = 0; i < n; i++) begin
            bus.data_in = 8'h00;
            tick(1);
            bus.sclk = 1'b1;
            tick(3);
            if (i == 0) check("oe_last_dummy", {31'h0, bus.oe}, 32'h0);
            bus.sclk = 1'b0;
            tick(3);
            pop_check("rd_data");
            check("rd_oe", {31'h0, bus.oe}, 32'h1);
        end
    endtask

    task automatic do_read(input logic [23:0] a, input int unsigned n, input logic [3:0][7:0] e);
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(e[i]);
        start_txn();
        send_byte(OP_READ);
        send_addr(a);
        read_phase(n);
        end_txn();
    endtask

    initial begin
        vecs[0] = mk(1'b1, 24'h000001, 1, 8'hAA, 8'h00, 8'h00, 8'h00);
        vecs[1] = mk(1'b0, 24'h000001, 1, 8'hAA, 8'h00, 8'h00, 8'h00);
        vecs[2] = mk(1'b1, 24'h0003FE, 4, 8'h11, 8'h22, 8'h33, 8'h44);
        vecs[3] = mk(1'b0, 24'h0003FE, 4, 8'h11, 8'h22, 8'h33, 8'h44);
        vecs[4] = mk(1'b0, 24'h000000, 1, 8'h33, 8'h00, 8'h00, 8'h00);
        vecs[5] = mk(1'b1, 24'h123401, 1, 8'h5A, 8'h00, 8'h00, 8'h00);
        vecs[6] = mk(1'b0, 24'h000001, 1, 8'h5A, 8'h00, 8'h00, 8'h00);
        vecs[7] = mk(1'b0, 24'h0003FF, 3, 8'h22, 8'h33, 8'h5A, 8'h00);
        vecs[8] = mk(1'b0, 24'hFFF401, 1, 8'h5A, 8'h00, 8'h00, 8'h00);

        reset       = 1'b0;
        bus.cs      = 1'b1;
        bus.sclk    = 1'b0;
        bus.data_in = 8'h00;
        tick(3);
        check("rst_oe",   {31'h0, bus.oe},        32'h0);
        check("rst_data", {24'h0, bus.data_out},  32'h0);
        check("rst_err",  {31'h0, bus.cmd_error}, 32'h0);
        check("rst_busy", {31'h0, bus.busy},      32'h0);
        reset = 1'b1;
        tick(3);

        foreach (vecs[k]) begin
            if (vecs[k].is_wr) do_write(vecs[k].addr, vecs[k].len, vecs[k].bytes);
            else               do_read(vecs[k].addr, vecs[k].len, vecs[k].bytes);
        end

        // Abort after two address bytes, then abort a data byte whose rise coincides with CS high.
        start_txn();
        check("busy_active", {31'h0, bus.busy}, 32'h1);
        send_byte(OP_WRITE);
        send_byte(8'h00);
        send_byte(8'h00);
        end_txn();
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_oe",   {31'h0, bus.oe},   32'h0);
        start_txn();
        send_byte(OP_WRITE);
        send_addr(24'h000002);
        bus.data_in = 8'hEE;
        tick(1);
        bus.sclk = 1'b1;
        bus.cs   = 1'b1;
        tick(3);
        bus.sclk = 1'b0;
        tick(3);
        check("race_busy", {31'h0, bus.busy}, 32'h0);
        do_read(24'h000002, 1, {8'h00, 8'h00, 8'h00, 8'h00});

        // CS high two clocks into a read's data phase: oe must drop shortly after.
        exp_q.push_back(8'h11);
        start_txn();
        send_byte(OP_READ);
        send_addr(24'h0003FE);
        read_phase(1);
        bus.cs = 1'b1;
        tick(3);
        check("cs_high_oe",   {31'h0, bus.oe},   32'h0);
        check("cs_high_busy", {31'h0, bus.busy}, 32'h0);
        tick(1);

        // Unknown opcode followed by bytes that would look like a write of 0x77 to 0x000009.
        check("err_before", {31'h0, bus.cmd_error}, 32'h0);
        start_txn();
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h09);
        check("bad_oe", {31'h0, bus.oe}, 32'h0);
        send_byte(8'h77);
        check("bad_err",  {31'h0, bus.cmd_error}, 32'h1);
        check("bad_busy", {31'h0, bus.busy},      32'h1);
        check("bad_oe2",  {31'h0, bus.oe},        32'h0);
        end_txn();
        check("err_sticky", {31'h0, bus.cmd_error}, 32'h1);
        do_read(24'h000009, 1, {8'h00, 8'h00, 8'h00, 8'h00});
        check("err_sticky2", {31'h0, bus.cmd_error}, 32'h1);

        // Asynchronous reset while the responder is driving the pad.
        exp_q.push_back(8'h11);
        start_txn();
        send_byte(OP_READ);
        send_addr(24'h0003FE);
        read_phase(1);
        #2 reset = 1'b0;
        #1;
        check("arst_oe",   {31'h0, bus.oe},        32'h0);
        check("arst_data", {24'h0, bus.data_out},  32'h0);
        check("arst_busy", {31'h0, bus.busy},      32'h0);
        check("arst_err",  {31'h0, bus.cmd_error}, 32'h0);
        bus.cs = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(3);
        do_read(24'h0003FE, 2, {8'h00, 8'h00, 8'h22, 8'h11});

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d expected bytes left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
